// File: rtl/lsu_pkg.sv
// Shared types, address offsets and lane helpers for the lsu_hs load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Word offsets inside the output and input peripheral windows.
  localparam logic [31:0] OFF_LEDR = 32'h0000_0000;
  localparam logic [31:0] OFF_LEDG = 32'h0000_0004;
  localparam logic [31:0] OFF_LCD  = 32'h0000_0008;
  localparam logic [31:0] OFF_HEX0 = 32'h0000_000C;
  localparam logic [31:0] OFF_SW   = 32'h0000_0000;
  localparam logic [31:0] OFF_BTN  = 32'h0000_0004;
  localparam logic [31:0] IN_SPAN  = 32'h0000_0008;

  function automatic logic lsu_f3_legal(input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: lsu_f3_legal = 1'b1;
      default:                             lsu_f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      LSU_H, LSU_HU: lsu_misaligned = a[0];
      LSU_W:         lsu_misaligned = |a;
      default:       lsu_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      LSU_B, LSU_BU: lsu_byte_en = 4'b0001 << a;
      LSU_H, LSU_HU: lsu_byte_en = 4'b0011 << a;
      LSU_W:         lsu_byte_en = 4'b1111;
      default:       lsu_byte_en = 4'b0000;
    endcase
  endfunction

  // Replicate the LSB-aligned store data so every candidate lane carries it.
  function automatic logic [31:0] lsu_st_lanes(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_BU: lsu_st_lanes = {4{d[7:0]}};
      LSU_H, LSU_HU: lsu_st_lanes = {2{d[15:0]}};
      default:       lsu_st_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] lsu_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      lsu_merge[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] lsu_extract(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [31:0] sh;
    sh = word >> {a, 3'b000};
    case (f3)
      LSU_B:   lsu_extract = {{24{sh[7]}}, sh[7:0]};
      LSU_BU:  lsu_extract = {24'h0, sh[7:0]};
      LSU_H:   lsu_extract = {{16{sh[15]}}, sh[15:0]};
      LSU_HU:  lsu_extract = {16'h0, sh[15:0]};
      LSU_W:   lsu_extract = sh;
      default: lsu_extract = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_hs_if.sv
// Request/response handshake bundle between the core (master) and the LSU (slave).
interface lsu_hs_if;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_st_data;
  logic        o_rsp_vld;
  logic        i_rsp_rdy;
  logic [31:0] o_ld_data;
  logic        o_rsp_err;

  modport master (
    output i_req_vld, i_lsu_addr, i_lsu_wren, i_funct3, i_st_data, i_rsp_rdy,
    input  o_req_rdy, o_rsp_vld, o_ld_data, o_rsp_err
  );

  modport slave (
    input  i_req_vld, i_lsu_addr, i_lsu_wren, i_funct3, i_st_data, i_rsp_rdy,
    output o_req_rdy, o_rsp_vld, o_ld_data, o_rsp_err
  );
endinterface

// File: rtl/lsu_dmem.sv
// Single-port synchronous data RAM with byte enables; write-first read port.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int WORDS = 2048
) (
  input  logic                     i_clk,
  input  logic                     i_en,
  input  logic [3:0]               i_we,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q, rdata_d;

  always_comb rdata_d = lsu_merge(mem[i_addr], i_wdata, i_we);

  // NOTE: the array has no reset branch so it maps onto block RAM; contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/lsu_hs.sv
// Load/store unit with valid/ready request, one-slot registered response, DMEM and board I/O.
module lsu_hs
  import lsu_pkg::*;
#(
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
  parameter logic [31:0] OUT_BASE   = 32'h0000_7000,
  parameter logic [31:0] IN_BASE    = 32'h0000_7800,
  parameter int          N_HEX      = 8,
  parameter int          BTN_W      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  lsu_hs_if.slave              bus,
  input  logic [31:0]          i_io_sw,
  input  logic [BTN_W-1:0]     i_io_btn,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [N_HEX*32-1:0]  o_io_hex
);

  localparam int          DMEM_AW   = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_MASK = 32'(DMEM_WORDS * 4 - 1);
  localparam logic [31:0] OUT_SPAN  = OFF_HEX0 + 32'(4 * N_HEX);

  rsp_state_e       rsp_state_q, rsp_state_d;
  logic             rsp_err_q, rsp_err_d;
  logic             ld_ok_q, ld_ok_d;
  logic             from_dmem_q, from_dmem_d;
  logic [1:0]       a_q, a_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      per_word_q, per_word_d;
  logic [31:0]      ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
  logic [31:0]      hex_q [N_HEX];
  logic [31:0]      hex_d [N_HEX];
  logic [31:0]      sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [BTN_W-1:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;

  logic        accept, req_err, dmem_hit, out_hit, in_hit, out_wr;
  logic [31:0] out_off, in_off, out_word, in_word, st_lanes, rd_word, out_rd, dmem_rdata;
  logic [3:0]  be, dmem_we;

  assign bus.o_req_rdy = (rsp_state_q == RSP_EMPTY) | bus.i_rsp_rdy;
  assign accept        = bus.i_req_vld & bus.o_req_rdy;

  // Address decode; subtracting the base lets one unsigned compare reject both sides.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    out_off  = bus.i_lsu_addr - OUT_BASE;
    in_off   = bus.i_lsu_addr - IN_BASE;
    out_word = {out_off[31:2], 2'b00};
    in_word  = {in_off[31:2], 2'b00};
    dmem_hit = (bus.i_lsu_addr & ~DMEM_MASK) == DMEM_BASE;
    out_hit  = out_off < OUT_SPAN;
    in_hit   = in_off < IN_SPAN;
    req_err  = !lsu_f3_legal(bus.i_funct3)
             | lsu_misaligned(bus.i_funct3, bus.i_lsu_addr[1:0])
             | !(dmem_hit | out_hit | in_hit)
             | (bus.i_lsu_wren & in_hit);
    be       = lsu_byte_en(bus.i_funct3, bus.i_lsu_addr[1:0]);
    st_lanes = lsu_st_lanes(bus.i_st_data, bus.i_funct3);
    dmem_we  = (accept & bus.i_lsu_wren & !req_err & dmem_hit) ? be : 4'b0000;
    out_wr   = accept & bus.i_lsu_wren & !req_err & out_hit;

    out_rd = 32'h0;
    if (out_word == OFF_LEDR) out_rd = ledr_q;
    if (out_word == OFF_LEDG) out_rd = ledg_q;
    if (out_word == OFF_LCD)  out_rd = lcd_q;
    for (int k = 0; k < N_HEX; k++) begin
      if (out_word == OFF_HEX0 + 32'(4 * k)) out_rd = hex_q[k];
    end
    rd_word = out_rd;
    if (in_hit) rd_word = (in_word == OFF_SW) ? sw_sync_q : 32'(btn_sync_q);
  end

  lsu_dmem #(.WORDS(DMEM_WORDS)) u_dmem (
    .i_clk   (i_clk),
    .i_en    (accept),
    .i_we    (dmem_we),
    .i_addr  (bus.i_lsu_addr[DMEM_AW+1:2]),
    .i_wdata (st_lanes),
    .o_rdata (dmem_rdata)
  );

  always_comb begin
    rsp_state_d = rsp_state_q;
    rsp_err_d   = rsp_err_q;
    ld_ok_d     = ld_ok_q;
    from_dmem_d = from_dmem_q;
    a_d         = a_q;
    f3_d        = f3_q;
    per_word_d  = per_word_q;
    ledr_d      = ledr_q;
    ledg_d      = ledg_q;
    lcd_d       = lcd_q;
    for (int k = 0; k < N_HEX; k++) hex_d[k] = hex_q[k];
    sw_meta_d   = i_io_sw;
    sw_sync_d   = sw_meta_q;
    btn_meta_d  = i_io_btn;
    btn_sync_d  = btn_meta_q;

    case (rsp_state_q)
      RSP_EMPTY: if (accept) rsp_state_d = RSP_FULL;
      RSP_FULL:  if (bus.i_rsp_rdy && !accept) rsp_state_d = RSP_EMPTY;
      default:   rsp_state_d = RSP_EMPTY;
    endcase

    if (accept) begin
      rsp_err_d   = req_err;
      ld_ok_d     = !bus.i_lsu_wren & !req_err;
      from_dmem_d = dmem_hit;
      a_d         = bus.i_lsu_addr[1:0];
      f3_d        = bus.i_funct3;
      per_word_d  = rd_word;
    end

    if (out_wr) begin
      if (out_word == OFF_LEDR) ledr_d = lsu_merge(ledr_q, st_lanes, be);
      if (out_word == OFF_LEDG) ledg_d = lsu_merge(ledg_q, st_lanes, be);
      if (out_word == OFF_LCD)  lcd_d  = lsu_merge(lcd_q, st_lanes, be);
      for (int k = 0; k < N_HEX; k++) begin
        if (out_word == OFF_HEX0 + 32'(4 * k)) hex_d[k] = lsu_merge(hex_q[k], st_lanes, be);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every _q updates from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_state_q <= RSP_EMPTY;
      rsp_err_q   <= 1'b0;
      ld_ok_q     <= 1'b0;
      from_dmem_q <= 1'b0;
      a_q         <= 2'b00;
      f3_q        <= 3'b000;
      per_word_q  <= 32'h0;
      ledr_q      <= 32'h0;
      ledg_q      <= 32'h0;
      lcd_q       <= 32'h0;
      for (int k = 0; k < N_HEX; k++) hex_q[k] <= 32'h0;
      sw_meta_q   <= 32'h0;
      sw_sync_q   <= 32'h0;
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
    end else begin
      rsp_state_q <= rsp_state_d;
      rsp_err_q   <= rsp_err_d;
      ld_ok_q     <= ld_ok_d;
      from_dmem_q <= from_dmem_d;
      a_q         <= a_d;
      f3_q        <= f3_d;
      per_word_q  <= per_word_d;
      ledr_q      <= ledr_d;
      ledg_q      <= ledg_d;
      lcd_q       <= lcd_d;
      for (int k = 0; k < N_HEX; k++) hex_q[k] <= hex_d[k];
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      btn_meta_q  <= btn_meta_d;
      btn_sync_q  <= btn_sync_d;
    end
  end

  // The RAM output only moves on accept, so the lane mux stays stable while the slot is held.
  always_comb begin
    bus.o_rsp_vld = (rsp_state_q == RSP_FULL);
    bus.o_rsp_err = bus.o_rsp_vld & rsp_err_q;
    bus.o_ld_data = 32'h0;
    if (bus.o_rsp_vld && ld_ok_q) begin
      bus.o_ld_data = lsu_extract(from_dmem_q ? dmem_rdata : per_word_q, f3_q, a_q);
    end
    o_io_hex = '0;
    for (int k = 0; k < N_HEX; k++) o_io_hex[32*k +: 32] = hex_q[k];
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs: vector table plus hand sequences for pipelining, sync and stalls.
module tb_lsu_hs;
  import lsu_pkg::*;

  localparam int N_HEX = 8;
  localparam int BTN_W = 4;

  typedef struct {
    string       name;
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         io_sw;
  logic [BTN_W-1:0]    io_btn;
  logic [31:0]         ledr, ledg, lcd;
  logic [N_HEX*32-1:0] hex;

  int   total = 0;
  int   bad   = 0;
  vec_t seq[$];

  lsu_hs_if bus ();

  lsu_hs #(.N_HEX(N_HEX), .BTN_W(BTN_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .i_io_sw   (io_sw),
    .i_io_btn  (io_btn),
    .o_io_ledr (ledr),
    .o_io_ledg (ledg),
    .o_io_lcd  (lcd),
    .o_io_hex  (hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic wren, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] st,
                              input logic [31:0] exp_data, input logic exp_err);
    vec_t v;
    v.name = name; v.wren = wren; v.f3 = f3; v.addr = addr; v.st = st;
    v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic add(input string name, input logic wren, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] st,
                     input logic [31:0] exp_data, input logic exp_err);
    seq.push_back(mk(name, wren, f3, addr, st, exp_data, exp_err));
  endtask

  task automatic drive(input vec_t v);
    bus.i_req_vld  = 1'b1;
    bus.i_lsu_wren = v.wren;
    bus.i_funct3   = v.f3;
    bus.i_lsu_addr = v.addr;
    bus.i_st_data  = v.st;
    bus.i_rsp_rdy  = 1'b1;
  endtask

  task automatic expect_rsp(input vec_t v);
    check({v.name, " vld"}, 32'(bus.o_rsp_vld), 32'd1);
    check({v.name, " data"}, bus.o_ld_data, v.exp_data);
    check({v.name, " err"}, 32'(bus.o_rsp_err), 32'(v.exp_err));
  endtask

  // Apply the queued vectors, either with an idle cycle between them or back-to-back.
  task automatic run_seq(input bit piped);
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      if (piped && i > 0) expect_rsp(seq[i-1]);
      drive(seq[i]);
      if (!piped) begin
        @(negedge clk);
        bus.i_req_vld = 1'b0;
        expect_rsp(seq[i]);
      end
    end
    if (piped && seq.size() > 0) begin
      @(negedge clk);
      bus.i_req_vld = 1'b0;
      expect_rsp(seq[seq.size()-1]);
    end
    seq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    io_sw = 32'h0;
    io_btn = '0;
    bus.i_req_vld = 1'b0;
    bus.i_lsu_wren = 1'b0;
    bus.i_funct3 = 3'b000;
    bus.i_lsu_addr = 32'h0;
    bus.i_st_data = 32'h0;
    bus.i_rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset vld", 32'(bus.o_rsp_vld), 32'd0);
    check("reset data", bus.o_ld_data, 32'h0);
    check("reset err", 32'(bus.o_rsp_err), 32'd0);
    check("reset req_rdy", 32'(bus.o_req_rdy), 32'd1);
    check("reset ledr", ledr, 32'h0);
    check("reset hex", hex[31:0], 32'h0);

    // Main table, one transaction at a time.
    add("sw_dmem",     1, LSU_W,  32'h2000, 32'hDEADBEEF, 32'h0,        0);
    add("lw_dmem",     0, LSU_W,  32'h2000, 32'h0,        32'hDEADBEEF, 0);
    add("lb_2003",     0, LSU_B,  32'h2003, 32'h0,        32'hFFFFFFDE, 0);
    add("lbu_2003",    0, LSU_BU, 32'h2003, 32'h0,        32'h000000DE, 0);
    add("lh_2002",     0, LSU_H,  32'h2002, 32'h0,        32'hFFFFDEAD, 0);
    add("lhu_2000",    0, LSU_HU, 32'h2000, 32'h0,        32'h0000BEEF, 0);
    add("sb_2001",     1, LSU_B,  32'h2001, 32'h00000012, 32'h0,        0);
    add("lw_after_sb", 0, LSU_W,  32'h2000, 32'h0,        32'hDEAD12EF, 0);
    add("sw_2004",     1, LSU_W,  32'h2004, 32'h11223344, 32'h0,        0);
    add("sh_2006",     1, LSU_H,  32'h2006, 32'h0000ABCD, 32'h0,        0);
    add("lw_2004",     0, LSU_W,  32'h2004, 32'h0,        32'hABCD3344, 0);
    add("lb_2004",     0, LSU_B,  32'h2004, 32'h0,        32'h00000044, 0);
    add("lh_2006",     0, LSU_H,  32'h2006, 32'h0,        32'hFFFFABCD, 0);
    add("lhu_2006",    0, LSU_HU, 32'h2006, 32'h0,        32'h0000ABCD, 0);
    add("sw_top",      1, LSU_W,  32'h3FFC, 32'hCAFEF00D, 32'h0,        0);
    add("lw_top",      0, LSU_W,  32'h3FFC, 32'h0,        32'hCAFEF00D, 0);
    add("lw_past_top", 0, LSU_W,  32'h4000, 32'h0,        32'h0,        1);
    add("lw_below",    0, LSU_W,  32'h1FFC, 32'h0,        32'h0,        1);
    add("lw_misalign", 0, LSU_W,  32'h2002, 32'h0,        32'h0,        1);
    add("lh_misalign", 0, LSU_H,  32'h2001, 32'h0,        32'h0,        1);
    add("sw_ledr",     1, LSU_W,  32'h7000, 32'h000003FF, 32'h0,        0);
    add("sh_7001",     1, LSU_H,  32'h7001, 32'h00005555, 32'h0,        1);
    add("lw_ledr",     0, LSU_W,  32'h7000, 32'h0,        32'h000003FF, 0);
    add("lw_unmapped", 0, LSU_W,  32'h5000, 32'h0,        32'h0,        1);
    add("sw_input",    1, LSU_W,  32'h7800, 32'h00000001, 32'h0,        1);
    add("ld_f3_011",   0, 3'b011, 32'h2000, 32'h0,        32'h0,        1);
    add("st_f3_011",   1, 3'b011, 32'h2000, 32'h0,        32'h0,        1);
    add("lw_no_write", 0, LSU_W,  32'h2000, 32'h0,        32'hDEAD12EF, 0);
    add("sw_hex_top",  1, LSU_W,  32'h7028, 32'h0000007F, 32'h0,        0);
    add("lw_hex_top",  0, LSU_W,  32'h7028, 32'h0,        32'h0000007F, 0);
    add("lw_past_hex", 0, LSU_W,  32'h702C, 32'h0,        32'h0,        1);
    add("sb_ledg",     1, LSU_B,  32'h7005, 32'h000000AB, 32'h0,        0);
    add("lbu_ledg",    0, LSU_BU, 32'h7005, 32'h0,        32'h000000AB, 0);
    add("lw_ledg",     0, LSU_W,  32'h7004, 32'h0,        32'h0000AB00, 0);
    add("sw_lcd",      1, LSU_W,  32'h7008, 32'h12345678, 32'h0,        0);
    add("lw_lcd",      0, LSU_W,  32'h7008, 32'h0,        32'h12345678, 0);
    run_seq(1'b0);

    check("ledr pin", ledr, 32'h000003FF);
    check("ledg pin", ledg, 32'h0000AB00);
    check("lcd pin", lcd, 32'h12345678);
    check("hex top pin", hex[32*(N_HEX-1) +: 32], 32'h0000007F);
    check("hex0 pin", hex[31:0], 32'h0);

    // Back-to-back read-after-write with no idle cycle.
    add("b2b_sw",  1, LSU_W, 32'h2008, 32'hDEADBEEF, 32'h0,        0);
    add("b2b_sb",  1, LSU_B, 32'h2009, 32'h00000012, 32'h0,        0);
    add("b2b_lw",  0, LSU_W, 32'h2008, 32'h0,        32'hDEAD12EF, 0);
    add("b2b_lb",  0, LSU_B, 32'h2009, 32'h0,        32'h00000012, 0);
    add("b2b_sh",  1, LSU_H, 32'h200A, 32'h00008001, 32'h0,        0);
    add("b2b_lh",  0, LSU_H, 32'h200A, 32'h0,        32'hFFFF8001, 0);
    run_seq(1'b1);

    // Input synchronisers: settle for two edges, then read.
    @(negedge clk);
    io_sw = 32'h000000A5;
    io_btn = 4'hA;
    @(posedge clk);
    @(posedge clk);
    add("lw_sw",  0, LSU_W, 32'h7800, 32'h0, 32'h000000A5, 0);
    add("lw_btn", 0, LSU_W, 32'h7804, 32'h0, 32'h0000000A, 0);
    run_seq(1'b1);
    // Change lands at T0; a load accepted 1.5 cycles later still sees the old value.
    io_sw = 32'h0000003C;
    add("sw_lat_old", 0, LSU_W, 32'h7800, 32'h0, 32'h000000A5, 0);
    add("sw_lat_new", 0, LSU_W, 32'h7800, 32'h0, 32'h0000003C, 0);
    run_seq(1'b1);

    // Backpressure: response held, second request blocked, then consume+accept together.
    @(negedge clk);
    drive(mk("bp_first", 0, LSU_W, 32'h2000, 32'h0, 32'hDEAD12EF, 0));
    bus.i_rsp_rdy = 1'b0;
    @(negedge clk);
    drive(mk("bp_second", 0, LSU_W, 32'h7000, 32'h0, 32'h000003FF, 0));
    bus.i_rsp_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp stall vld", 32'(bus.o_rsp_vld), 32'd1);
      check("bp stall data", bus.o_ld_data, 32'hDEAD12EF);
      check("bp stall req_rdy", 32'(bus.o_req_rdy), 32'd0);
      @(negedge clk);
    end
    bus.i_rsp_rdy = 1'b1;
    #1;
    check("bp release req_rdy", 32'(bus.o_req_rdy), 32'd1);
    @(negedge clk);
    check("bp second vld", 32'(bus.o_rsp_vld), 32'd1);
    check("bp second data", bus.o_ld_data, 32'h000003FF);
    bus.i_req_vld = 1'b0;
    bus.i_rsp_rdy = 1'b0;
    @(negedge clk);
    check("bp held vld", 32'(bus.o_rsp_vld), 32'd1);
    check("bp held data", bus.o_ld_data, 32'h000003FF);

    // Reset while a response is pending drops it and clears peripherals, not DMEM.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst pending vld", 32'(bus.o_rsp_vld), 32'd0);
    check("rst pending data", bus.o_ld_data, 32'h0);
    check("rst ledr", ledr, 32'h0);
    check("rst hex top", hex[32*(N_HEX-1) +: 32], 32'h0);
    add("post_rst_dmem", 0, LSU_W, 32'h2000, 32'h0, 32'hDEAD12EF, 0);
    add("post_rst_ledr", 0, LSU_W, 32'h7000, 32'h0, 32'h0,        0);
    run_seq(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
- Parametrised load/store unit for the RISC-V core. It replaces the purely combinational LSU with a valid/ready request channel and a registered response channel.
- Data memory is synchronous-read block RAM. Load data is sign- or zero-extended per funct3.
- Misaligned and unmapped accesses are detected and flagged.
- Output/input peripheral counts are configurable. Asynchronous board inputs are synchronised inside the block.

Parameters:
- DMEM_WORDS, 2048, data memory depth in 32-bit words (power of two)
- DMEM_BASE, 32'h0000_2000, data memory base byte address (aligned to DMEM_WORDS*4)
- OUT_BASE, 32'h0000_7000, output peripheral base
- IN_BASE, 32'h0000_7800, input peripheral base
- N_HEX, 8, number of 7-segment registers (1..13)
- BTN_W, 4, button width (1..32)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_req_vld  in  1  request valid
- o_req_rdy  out  1  request accepted when i_req_vld & o_req_rdy
- i_lsu_addr  in  32  byte address
- i_lsu_wren  in  1  1 = store, 0 = load
- i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- i_st_data  in  32  store data, LSB-aligned
- o_rsp_vld  out  1  response valid
- i_rsp_rdy  in  1  response consumed when o_rsp_vld & i_rsp_rdy
- o_ld_data  out  32  extended load data (0 for stores/errors)
- o_rsp_err  out  1  misaligned, unmapped, or illegal funct3
- i_io_sw  in  32  switches (asynchronous)
- i_io_btn  in  BTN_W  buttons (asynchronous)
- o_io_ledr  out  32  red LEDs
- o_io_ledg  out  32  green LEDs
- o_io_lcd  out  32  LCD register
- o_io_hex  out  N_HEX*32  hex k at bits [32k+31:32k]

Behaviour:
- Reset (synchronous): o_rsp_vld=0, o_ld_data=0, o_rsp_err=0, all output peripheral registers=0, synchroniser flops=0. Any pending response is dropped. DMEM contents are not reset.
- Flow control: o_req_rdy = !o_rsp_vld | i_rsp_rdy (combinational). This gives one request per cycle at full throughput.
- Latency: accept in cycle N; response in cycle N+1. o_rsp_vld, o_ld_data and o_rsp_err are held stable until consumed.
- Response state: one response slot, RSP_EMPTY/RSP_FULL.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on simultaneous consume+accept.
  - FULL -> EMPTY on consume without accept.
- Address map:
  - DMEM: [DMEM_BASE, DMEM_BASE+4*DMEM_WORDS).
  - OUT_BASE+0x00 ledr, +0x04 ledg, +0x08 lcd, +0x0C+4k hex k.
  - IN_BASE+0x00 switches, +0x04 buttons (zero-extended).
  - Every other address is unmapped.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
- Error handling:
  - Error sources: misalignment, unmapped address, funct3 not in {000,001,010,100,101}, or any store to the input range.
  - On error: o_rsp_err=1, o_ld_data=0, and no state changes.
- Stores:
  - Byte enables: B = 0001<<a[1:0]; H = 0011<<a[1:0]; W = 1111.
  - Lane data is the LSB of i_st_data replicated to the addressed lane.
  - DMEM and output registers are written in the accept cycle, so a load accepted in cycle N+1 sees the new data.
- Loads:
  - The word is read synchronously and the lane is selected using the registered a[1:0] and funct3.
  - B/H are sign-extended; BU/HU are zero-extended.
  - Output registers read back their stored value.
- Input synchronisation: i_io_sw and i_io_btn pass through 2-flop synchronisers. Loads return the synchronised value, giving a 2-cycle input latency.
- Read-after-write to the same word on back-to-back requests returns the new data. DMEM must be write-first, or a bypass register must be provided.

Decomposition:
- Package lsu_pkg holds:
  - funct3 enum (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - peripheral offset constants;
  - function lsu_byte_en(funct3, a[1:0]) returning [3:0];
  - function lsu_extract(word, funct3, a[1:0]) returning the extended 32-bit data.
- Sub-module lsu_dmem: single-port synchronous RAM with byte enables, write-first, depth DMEM_WORDS.

Test Plan:
- Reset then SW 0x2000=0xDEADBEEF, LW 0x2000 -> rsp next cycle, o_ld_data=0xDEADBEEF, err=0.
- Extension: LB 0x2003 -> 0xFFFFFFDE; LBU 0x2003 -> 0x000000DE; LH 0x2002 -> 0xFFFFDEAD; LHU 0x2000 -> 0x0000BEEF.
- SB 0x2001 data 0x12 over 0xDEADBEEF, then LW -> 0xDEAD12EF. Back-to-back with no idle cycle must also return 0xDEAD12EF.
- Error cases, each giving err=1, ld_data=0 and no write:
  - LW 0x2002;
  - SH 0x7001;
  - LW 0x5000;
  - SW 0x7800;
  - funct3=011.
  - LEDR is unchanged after SH 0x7001.
- Peripherals: SW 0x7000=0x3FF -> o_io_ledr=0x3FF next cycle. SW 0x700C+4*(N_HEX-1)=0x7F -> top hex=0x7F. Set i_io_sw=0xA5 and wait 2 cycles; LW 0x7800 -> 0xA5.
- Backpressure: hold i_rsp_rdy=0 for 3 cycles -> rsp stable and o_req_rdy=0. Release -> consume and accept in the same cycle. Assert i_rst while rsp is pending -> o_rsp_vld=0 next cycle and LEDR=0.
